// File: rtl/bz_link_arbiter.sv
// rtl/bz_link_arbiter.sv - packet-atomic round-robin arbiter serialising packets onto the 11-bit link
// Optional feature macro: BZ_LINK_PARITY_EN (even parity over the payload in D2 bit 10)
module bz_link_arbiter #(
  parameter  int NUM_SRC = 2,
  parameter  int CNT_W   = 16,
  localparam int GW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC*10-1:0]   src_route,
  input  logic [NUM_SRC*32-1:0]   src_payload,
  output logic [10:0]             top_out,
  output logic                    top_valid_out,
  input  logic                    top_ready_out,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_D0   = 3'd2,
    S_D1   = 3'd3,
    S_D2   = 3'd4
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_ptr;
  logic [GW-1:0]      r_grant;
  logic [31:0]        r_payload;
  logic [10:0]        r_top_out;
  logic               r_top_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_pkt_count;

  logic [9:0]         w_route   [NUM_SRC];
  logic [31:0]        w_payload [NUM_SRC];
  logic               w_load;
  logic               w_found;
  logic [GW-1:0]      w_pick;
  logic [GW-1:0]      w_idx;
  logic [GW-1:0]      w_next_ptr;
  logic [NUM_SRC-1:0] w_src_ready;
  logic               w_xfer;
  logic               w_d2_msb;

  // Unpack the flat per-source buses so the picked source can be indexed directly
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_route[g]   = src_route[10*g +: 10];
    assign w_payload[g] = src_payload[32*g +: 32];
  end

`ifdef BZ_LINK_PARITY_EN
  assign w_d2_msb = ^r_payload;
`else
  assign w_d2_msb = 1'b0;
`endif

  // A new packet may be taken when idle or when the last data flit leaves this cycle
  assign w_xfer = r_top_valid & top_ready_out;
  assign w_load = (r_state == S_IDLE) | ((r_state == S_D2) & top_ready_out);

  // Round-robin search: first valid source at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = r_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && src_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
      w_idx = (w_idx == GW'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_next_ptr = (w_pick == GW'(NUM_SRC - 1)) ? '0 : w_pick + 1'b1;

  // Accept handshake is combinational so the source sees it in the load cycle
  always_comb begin
    w_src_ready = '0;
    if (w_load && w_found) begin
      w_src_ready[w_pick] = 1'b1;
    end
  end

  // Packet FSM: walks header and three data flits, reloading at the packet boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_payload   <= '0;
      r_top_out   <= '0;
      r_top_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (top_ready_out) begin
            r_top_out <= r_payload[10:0];
            r_state   <= S_D0;
          end
        end
        S_D0: begin
          if (top_ready_out) begin
            r_top_out <= r_payload[21:11];
            r_state   <= S_D1;
          end
        end
        S_D1: begin
          if (top_ready_out) begin
            r_top_out <= {w_d2_msb, r_payload[31:22]};
            r_state   <= S_D2;
          end
        end
        S_D2: begin
          if (w_xfer) begin
            r_pkt_count <= r_pkt_count + 1'b1;
          end
        end
        default: begin
        end
      endcase

      // Packet boundary: start the next packet or fall back to idle
      if (w_load) begin
        if (w_found) begin
          r_payload   <= w_payload[w_pick];
          r_top_out   <= {1'b0, w_route[w_pick]};
          r_top_valid <= 1'b1;
          r_busy      <= 1'b1;
          r_grant     <= w_pick;
          r_ptr       <= w_next_ptr;
          r_state     <= S_HDR;
        end else begin
          r_top_out   <= '0;
          r_top_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      end
    end
  end

  assign src_ready     = w_src_ready;
  assign top_out       = r_top_out;
  assign top_valid_out = r_top_valid;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_bz_link_arbiter.sv
// tb/tb_bz_link_arbiter.sv - randomized and directed checks of bz_link_arbiter against a queue-based model
module tb_bz_link_arbiter;

  localparam int N  = 3;
  localparam int CW = 2;
  localparam int GW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*10-1:0]   src_route;
  logic [N*32-1:0]   src_payload;
  logic [10:0]       top_out;
  logic              top_valid_out;
  logic              top_ready_out;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic [CW-1:0]     pkt_count;

  bz_link_arbiter #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_route     (src_route),
    .src_payload   (src_payload),
    .top_out       (top_out),
    .top_valid_out (top_valid_out),
    .top_ready_out (top_ready_out),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: flits still owed on the link, arbitration pointer, owner and packet count
  logic [10:0] m_flits[$];
  int          m_ptr   = 0;
  int          m_grant = 0;
  int          m_cnt   = 0;

  // Values seen at the most recent sampling point, for directed checks
  logic [10:0]  s_out;
  logic         s_valid;
  logic         s_busy;
  logic [N-1:0] s_ready;
  int           s_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] d2_flit(input logic [31:0] p);
`ifdef BZ_LINK_PARITY_EN
    return {^p, p[31:22]};
`else
    return {1'b0, p[31:22]};
`endif
  endfunction

  task automatic set_src(input int k, input logic [9:0] r, input logic [31:0] p);
    src_route[k*10 +: 10]   = r;
    src_payload[k*32 +: 32] = p;
  endtask

  // One clock cycle: compare outputs to the model, then advance the model across the edge
  task automatic tick();
    bit          load;
    bit          found;
    int          pick;
    int          k;
    logic [N-1:0] exp_ready;
    logic [9:0]  r;
    logic [31:0] p;
    @(negedge clk);
    s_out   = top_out;
    s_valid = top_valid_out;
    s_busy  = busy;
    s_ready = src_ready;
    s_cnt   = int'(pkt_count);
    chk("valid", top_valid_out, m_flits.size() != 0);
    chk("busy", busy, m_flits.size() != 0);
    chk("pkt_count", pkt_count, m_cnt);
    if (m_flits.size() != 0) begin
      chk("flit", top_out, m_flits[0]);
      chk("grant_id", grant_id, m_grant);
    end
    load  = (m_flits.size() == 0) || (m_flits.size() == 1 && top_ready_out);
    found = 1'b0;
    pick  = 0;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (!found && src_valid[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
    exp_ready = '0;
    if (load && found) exp_ready[pick] = 1'b1;
    chk("src_ready", src_ready, exp_ready);
    if (m_flits.size() != 0 && top_ready_out) begin
      void'(m_flits.pop_front());
      if (m_flits.size() == 0) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (load && found) begin
      r = src_route[pick*10 +: 10];
      p = src_payload[pick*32 +: 32];
      m_flits.push_back({1'b0, r});
      m_flits.push_back(p[10:0]);
      m_flits.push_back(p[21:11]);
      m_flits.push_back(d2_flit(p));
      m_grant = pick;
      m_ptr   = (pick + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  int n_flits;
  int n_pulses;

  initial begin
    reset_n       = 1'b0;
    src_valid     = '0;
    src_route     = '0;
    src_payload   = '0;
    top_ready_out = 1'b1;
    #12;
    chk("rst_valid", top_valid_out, 1'b0);
    chk("rst_out", top_out, 11'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_ready", src_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single packet with continuous ready
    set_src(0, 10'd3, 32'h4C70F07C);
    src_valid = 3'b001;
    tick();
    chk("acc_ready", s_ready, 3'b001);
    src_valid = '0;
    tick();
    chk("hdr", s_out, 11'h003);
    tick();
    chk("d0", s_out, 11'h07C);
    tick();
    chk("d1", s_out, 11'h61E);
    tick();
`ifdef BZ_LINK_PARITY_EN
    chk("d2", s_out, 11'h531);
`else
    chk("d2", s_out, 11'h131);
`endif
    tick();
    chk("done_busy", s_busy, 1'b0);
    chk("done_count", s_cnt, 1);

    // Backpressure while D0 is presented
    src_valid = 3'b001;
    tick();
    src_valid = '0;
    tick();
    top_ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", s_out, 11'h07C);
    end
    top_ready_out = 1'b1;
    tick();
    chk("bp_d0", s_out, 11'h07C);
    tick();
    chk("bp_d1", s_out, 11'h61E);
    tick();
    tick();
    chk("bp_count", s_cnt, 2);

    // Reset while D1 is on the link
    src_valid = 3'b001;
    tick();
    src_valid = '0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", top_valid_out, 1'b0);
    chk("mid_rst_count", pkt_count, 0);
    chk("mid_rst_busy", busy, 1'b0);
    m_flits.delete();
    m_ptr = 0;
    m_grant = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_src(1, 10'h2A5, 32'h1234_5678);
    src_valid = 3'b010;
    tick();
    chk("post_rst_ready", s_ready, 3'b010);
    src_valid = '0;
    tick();
    chk("post_rst_hdr", s_out, 11'h2A5);
    for (int i = 0; i < 4; i++) tick();

    // Fairness between two continuously valid sources
    set_src(0, 10'd1, $urandom);
    set_src(1, 10'd2, $urandom);
    src_valid = 3'b011;
    n_flits  = 0;
    n_pulses = 0;
    for (int t = 0; t < 17; t++) begin
      tick();
      if (t < 16 && s_ready != 0) n_pulses++;
      if (t >= 1 && s_valid) n_flits++;
      if (t == 1 || t == 9)  chk("fair_hdr_a", s_out, 11'h001);
      if (t == 5 || t == 13) chk("fair_hdr_b", s_out, 11'h002);
    end
    chk("fair_flits", n_flits, 16);
    chk("fair_pulses", n_pulses, 4);
    src_valid = '0;
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic, including counter wrap
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) set_src(k, 10'($urandom), $urandom);
      src_valid     = N'($urandom_range(0, (1 << N) - 1));
      top_ready_out = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bz_link_arbiter.md
Name: bz_link_arbiter

Overview:
- Packet-atomic round-robin arbiter between NUM_SRC on-board packet sources that all share the 11-bit board-to-board output link (top_out / top_valid_out / top_ready_out) in BZ_host_core.
- Each source presents one whole packet: a 10-bit route plus a 32-bit payload.
- The block grants one source, latches that source's packet, and serialises it onto the link as one header flit followed by three data flits.
- Grants rotate so that no source can starve another.

Parameters:
- NUM_SRC, 2, number of packet requesters (2..8).
- CNT_W, 16, width of the transmitted-packet counter.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- src_valid  input  NUM_SRC  per-source packet-valid.
- src_ready  output  NUM_SRC  per-source packet-accept; one-hot or zero.
- src_route  input  NUM_SRC*10  packed routes; source k occupies bits [10k+9:10k].
- src_payload  input  NUM_SRC*32  packed payloads; source k occupies bits [32k+31:32k].
- top_out  output  11  link flit.
- top_valid_out  output  1  flit valid.
- top_ready_out  input  1  downstream ready.
- grant_id  output  $clog2(NUM_SRC) (minimum 1)  index of the source currently being serialised.
- busy  output  1  high while a packet is held.
- pkt_count  output  CNT_W  number of packets fully sent.

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, top_valid_out=0, top_out=0, src_ready=0, grant_id=0, busy=0, pkt_count=0, round-robin pointer=0.
- States: IDLE, HDR, D0, D1, D2. busy=1 and top_valid_out=1 in every state except IDLE.
- Flit format:
  - HDR = {1'b0, route[9:0]}
  - D0 = payload[10:0]
  - D1 = payload[21:11]
  - D2 = {1'b0, payload[31:22]}
- Flit handshake:
  - A flit transfers on any clk edge where top_valid_out & top_ready_out.
  - top_out and top_valid_out are registered and stay stable while top_ready_out=0.
  - Transitions on transfer: HDR->D0, D0->D1, D1->D2.
- Load condition:
  - load = (state==IDLE) | (state==D2 & top_ready_out).
  - When load holds and any src_valid is high, the arbiter picks the first valid source at or after the pointer, wrapping modulo NUM_SRC.
  - src_ready for the picked source is high combinationally in that same cycle; that is the packet's accept handshake.
  - On the clock edge: route and payload are latched, grant_id is set to the picked source, state goes to HDR, and the pointer becomes pick+1 (mod NUM_SRC).
- Load with no src_valid high: state goes to IDLE and top_valid_out drops.
- Throughput: back-to-back packets run with no bubble, i.e. 4 flits per packet at 1 flit per cycle.
- Latency: src_valid high in IDLE -> header on top_out in the next cycle.
- Grant lifetime:
  - src_ready is only ever asserted under the load condition.
  - A source that drops src_valid mid-packet does not affect a packet already latched.
  - Grant changes only at packet boundaries; flits from different sources never interleave.
- pkt_count increments on transfer of D2 and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-packet aborts the packet immediately (all outputs return to reset values). The partial packet is not resent.
- Single requester stays continuously valid: that requester is granted every packet.
- All NUM_SRC requesters continuously valid: grants go 0,1,...,NUM_SRC-1,0,... in strict order.

Optional Feature:
- Macro: BZ_LINK_PARITY_EN.
- When defined: D2 bit 10 = ^payload[31:0], i.e. the even-parity bit over the payload, so the total count of ones across payload plus that bit is even.
- When undefined: D2 bit 10 is always 0 and no parity logic is synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Packet path, parity off:
  - src0 route=10'd3, payload=0x4C70F07C, top_ready_out=1 -> flits 0x003, 0x07C, 0x61E, 0x131 on consecutive cycles.
  - pkt_count=1, busy=0 afterwards.
- Same packet with BZ_LINK_PARITY_EN defined -> D2 = 0x531; the other three flits are unchanged.
- Downstream backpressure: top_ready_out low for 3 cycles while D0 is presented -> top_out holds 0x07C unchanged; D1 follows 1 cycle after ready returns; no flit is lost or duplicated.
- Fairness, NUM_SRC=2:
  - Both sources continuously valid with routes 1 and 2.
  - Headers observed: 0x001, 0x002, 0x001, 0x002, ...
  - Exactly 16 flits over 16 cycles with no bubbles; src_ready pulses exactly once per packet.
- Reset mid-packet: reset_n low during D1 -> top_valid_out=0 immediately, pkt_count=0; after release with src1 valid -> a clean header for src1 next cycle.
- Counter wrap: CNT_W=2, send 5 packets -> pkt_count sequence 1,2,3,0,1.
